// File: rtl/load_extend_if.sv
// Load request / data-memory read bundle between the control FSM,
// the load-extend unit and data memory.
interface load_extend_if;
  logic        start;
  logic [2:0]  load_type;
  logic [1:0]  addr_lo;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_err;

  // Requester / memory side
  modport master (
    output start, load_type, addr_lo, mem_rd_ack, mem_rdata,
    input  mem_rd_req, busy, done, load_data, misalign, bus_err
  );

  // Load-extend unit side
  modport slave (
    input  start, load_type, addr_lo, mem_rd_ack, mem_rdata,
    output mem_rd_req, busy, done, load_data, misalign, bus_err
  );
endinterface

// File: rtl/load_extend_unit.sv
// Load-extend unit: issues one word read per load, picks the addressed
// byte/halfword, sign- or zero-extends it and holds it MDR-style.
module load_extend_unit #(
  parameter int CHECK_ALIGN = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  load_extend_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    type_q, type_d;
  logic [1:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;

  logic          type_ok, misaligned;

  // Lane select and extension from the latched type/address
  function automatic logic [31:0] extend(logic [2:0] t, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (t)
      LT_LH:   extend = {{16{h[15]}}, h};
      LT_LHU:  extend = {16'h0000, h};
      LT_LB:   extend = {{24{b[7]}}, b};
      LT_LBU:  extend = {24'h000000, b};
      default: extend = w;
    endcase
  endfunction

  assign type_ok    = (bus.load_type <= LT_LBU);
  assign misaligned = (CHECK_ALIGN != 0) &&
                      (((bus.load_type == LT_LW) && (bus.addr_lo != 2'b00)) ||
                       (((bus.load_type == LT_LH) || (bus.load_type == LT_LHU)) && bus.addr_lo[0]));

  // Next-state and register updates for the load sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && type_ok) begin
          type_d = bus.load_type;
          addr_d = bus.addr_lo;
          berr_d = 1'b0;
          mis_d  = misaligned;
          if (misaligned) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        // An ack arriving on the last allowed cycle still completes normally
        if (bus.mem_rd_ack) begin
          data_d  = extend(type_q, addr_q, bus.mem_rdata);
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          berr_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.mem_rd_req = (state_q == S_WAIT);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.load_data  = data_q;
  assign bus.misalign   = mis_q;
  assign bus.bus_err    = berr_q;
endmodule

// File: tb/tb_load_extend_unit.sv
// Directed bench for load_extend_unit: extension per load type, alignment
// rejects, timeout, ignored stimulus and mid-transfer reset.
module tb_load_extend_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  load_extend_if b  ();
  load_extend_if b0 ();

  load_extend_unit #(.CHECK_ALIGN(1), .TIMEOUT(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  load_extend_unit #(.CHECK_ALIGN(0), .TIMEOUT(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load on the CHECK_ALIGN=1 unit, ack after nwait WAIT cycles
  task automatic do_load(input string tag, input logic [2:0] t, input logic [1:0] a,
                         input logic [31:0] rd, input int nwait, input logic [31:0] exp);
    b.start = 1'b1; b.load_type = t; b.addr_lo = a;
    tick();
    b.start = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      chk({tag, "_req"}, 32'(b.mem_rd_req), 32'd1);
      tick();
    end
    b.mem_rd_ack = 1'b1; b.mem_rdata = rd;
    tick();
    b.mem_rd_ack = 1'b0; b.mem_rdata = 32'h0;
    chk({tag, "_done"}, 32'(b.done), 32'd1);
    chk({tag, "_data"}, b.load_data, exp);
    chk({tag, "_flags"}, {30'd0, b.misalign, b.bus_err}, 32'd0);
    tick();
    chk({tag, "_done_pulse"}, {30'd0, b.done, b.busy}, 32'd0);
  endtask

  initial begin
    b.start = 0; b.load_type = 0; b.addr_lo = 0; b.mem_rd_ack = 0; b.mem_rdata = 0;
    b0.start = 0; b0.load_type = 0; b0.addr_lo = 0; b0.mem_rd_ack = 0; b0.mem_rdata = 0;

    // Reset values
    tick(); tick();
    chk("rst_data", b.load_data, 32'h0);
    chk("rst_ctl", {26'd0, b.done, b.misalign, b.bus_err, b.mem_rd_req, b.busy, 1'b0}, 32'h0);
    rst_n = 1'b1;
    tick();

    // LB addr 01 with two wait cycles, then the single-cycle-ack cases
    do_load("lb01",  3'd3, 2'b01, 32'h8899AABB, 1, 32'hFFFFFFAA);
    do_load("lbu11", 3'd4, 2'b11, 32'h8899AABB, 0, 32'h00000088);
    do_load("lh10",  3'd1, 2'b10, 32'h8899AABB, 0, 32'hFFFF8899);
    do_load("lhu00", 3'd2, 2'b00, 32'h8899AABB, 0, 32'h0000AABB);
    do_load("lw00",  3'd0, 2'b00, 32'h8899AABB, 0, 32'h8899AABB);

    // Misaligned LW rejected without a read
    b.start = 1'b1; b.load_type = 3'd0; b.addr_lo = 2'b01;
    tick();
    b.start = 1'b0;
    chk("mis_done", 32'(b.done), 32'd1);
    chk("mis_flag", 32'(b.misalign), 32'd1);
    chk("mis_req", 32'(b.mem_rd_req), 32'd0);
    chk("mis_data", b.load_data, 32'h8899AABB);
    tick();
    chk("mis_hold", {30'd0, b.misalign, b.done}, 32'd2);

    // Same request with alignment checking off reads the full word
    b0.start = 1'b1; b0.load_type = 3'd0; b0.addr_lo = 2'b01;
    tick();
    b0.start = 1'b0;
    chk("na_req", 32'(b0.mem_rd_req), 32'd1);
    b0.mem_rd_ack = 1'b1; b0.mem_rdata = 32'h8899AABB;
    tick();
    b0.mem_rd_ack = 1'b0;
    chk("na_data", b0.load_data, 32'h8899AABB);
    chk("na_flags", {29'd0, b0.done, b0.misalign, b0.bus_err}, 32'd4);
    tick();

    // Timeout: 16 cycles of request, then bus_err with data unchanged
    b.start = 1'b1; b.load_type = 3'd3; b.addr_lo = 2'b00;
    tick();
    b.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_req", {30'd0, b.mem_rd_req, b.done}, 32'd2);
      tick();
    end
    chk("to_done", 32'(b.done), 32'd1);
    chk("to_flags", {30'd0, b.misalign, b.bus_err}, 32'd1);
    chk("to_data", b.load_data, 32'h8899AABB);
    chk("to_req_off", 32'(b.mem_rd_req), 32'd0);
    tick();
    chk("to_hold", {30'd0, b.bus_err, b.done}, 32'd2);

    // Ack on the 16th WAIT cycle wins over the timeout
    do_load("ack16", 3'd0, 2'b00, 32'h12345678, 15, 32'h12345678);

    // Start while busy is ignored
    b.start = 1'b1; b.load_type = 3'd4; b.addr_lo = 2'b00;
    tick();
    b.load_type = 3'd0;
    tick();
    b.start = 1'b0;
    chk("busy_start", {30'd0, b.mem_rd_req, b.done}, 32'd2);
    b.mem_rd_ack = 1'b1; b.mem_rdata = 32'h000000C3;
    tick();
    b.mem_rd_ack = 1'b0;
    chk("busy_data", b.load_data, 32'h000000C3);
    tick();

    // Stray ack in IDLE
    b.mem_rd_ack = 1'b1; b.mem_rdata = 32'hDEADBEEF;
    tick(); tick();
    b.mem_rd_ack = 1'b0;
    chk("stray_ctl", {30'd0, b.busy, b.done}, 32'd0);
    chk("stray_data", b.load_data, 32'h000000C3);

    // Misaligned LH, then an invalid type leaves the flag alone
    b.start = 1'b1; b.load_type = 3'd1; b.addr_lo = 2'b01;
    tick();
    b.start = 1'b0;
    chk("mislh", {30'd0, b.misalign, b.done}, 32'd3);
    tick();
    b.start = 1'b1; b.load_type = 3'd7; b.addr_lo = 2'b00;
    tick(); tick();
    b.start = 1'b0;
    chk("inv_ctl", {29'd0, b.busy, b.done, b.mem_rd_req}, 32'd0);
    chk("inv_flag", 32'(b.misalign), 32'd1);
    do_load("lb_after", 3'd3, 2'b00, 32'h0000007F, 0, 32'h0000007F);

    // Reset in the middle of WAIT
    b.start = 1'b1; b.load_type = 3'd0; b.addr_lo = 2'b00;
    tick();
    b.start = 1'b0;
    chk("rw_req", 32'(b.mem_rd_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_ctl", {26'd0, b.done, b.misalign, b.bus_err, b.mem_rd_req, b.busy, 1'b0}, 32'h0);
    chk("rw_data", b.load_data, 32'h0);
    b.mem_rd_ack = 1'b1; b.mem_rdata = 32'hCAFEF00D;
    tick();
    b.mem_rd_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rw_after", {29'd0, b.busy, b.done, b.mem_rd_req}, 32'd0);
    chk("rw_after_data", b.load_data, 32'h0);
    do_load("lb_rst", 3'd3, 2'b10, 32'h00800000, 0, 32'hFFFFFF80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Read-side counterpart of the store byte-enable logic in the multicycle datapath.
- Accepts one load request (load type plus low address bits) from the control FSM and issues a word read to data memory.
- Waits for a variable-latency acknowledge, selects the addressed byte or halfword, and sign- or zero-extends it to 32 bits.
- Holds the result in an MDR-style register for the write-back state, and flags misaligned accesses and memory timeouts.

Parameters:
- CHECK_ALIGN, 1: 1 = misaligned LW/LH/LHU is rejected without a memory read. 0 = alignment is not checked; halves are selected by addr_lo[1] and words ignore addr_lo.
- TIMEOUT, 16: number of WAIT cycles without ack before the unit aborts with bus_err. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load request strobe; sampled only in IDLE.
- load_type  in  3  encoding: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU. 101-111 are invalid.
- addr_lo  in  2  ALUOut[1:0] of the effective address.
- mem_rd_req  out  1  word read request to data memory.
- mem_rd_ack  in  1  memory response; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  little-endian word. Lane 0 = [7:0], lane 3 = [31:24].
- busy  out  1  high whenever the unit is not in IDLE.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended result, held until the next successful load.
- misalign  out  1  sticky error flag for the last accepted request.
- bus_err  out  1  sticky timeout flag for the last accepted request.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. load_data, done, misalign, bus_err, mem_rd_req, busy, wait counter and latched type/addr all 0.
- FSM states:
  - IDLE: on start with a valid load_type, latch load_type and addr_lo, clear misalign and bus_err.
    - If CHECK_ALIGN=1 and the access is misaligned (LW with addr_lo!=00; LH/LHU with addr_lo[0]=1): go to DONE and set misalign.
    - Otherwise go to WAIT and clear the counter.
    - start with an invalid load_type: ignored, stay IDLE, flags unchanged.
  - WAIT: mem_rd_req=1, driven combinationally from state.
    - On mem_rd_ack: load_data <= extend(mem_rdata), go to DONE.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: set bus_err, go to DONE, load_data unchanged.
    - Else counter+1.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- busy = (state!=IDLE). start while busy is ignored; a new start is accepted in the cycle after done.
- Latency: start at cycle T, mem_rd_req high from T+1. Ack at T+1+k gives done and a valid load_data at T+2+k. A misaligned reject gives done at T+1.
- Extension, using the latched addr:
  - LW: the full word.
  - LB/LBU: byte lane addr_lo; LB replicates bit 7 into [31:8], LBU zero-fills.
  - LH/LHU: lane pair selected by addr_lo[1] (0 selects [15:0], 1 selects [31:16]); LH replicates bit 15 into [31:16], LHU zero-fills.
- mem_rd_ack outside WAIT is ignored.
- Ack in the same cycle the timeout is reached: ack wins, no bus_err.
- Counter width is clog2(TIMEOUT)+1 and it never wraps.
- rst_n asserted mid-WAIT: immediate return to reset values; mem_rd_req drops asynchronously; a late ack is ignored.
- misalign and bus_err are never both set. Both are held until the next accepted start.

Test Plan:
- LB, addr_lo=01, ack after 2 cycles with mem_rdata=0x8899AABB -> done one cycle after ack, load_data=0xFFFFFFAA, flags 0.
- LBU addr 11 -> 0x00000088. LH addr 10 -> 0xFFFF8899. LHU addr 00 -> 0x0000AABB. LW addr 00 -> 0x8899AABB. Each uses ack in the first WAIT cycle, so done arrives at T+2.
- CHECK_ALIGN=1, LW addr_lo=01 -> mem_rd_req never asserted, done at T+1, misalign=1, load_data keeps its previous value. Repeat with CHECK_ALIGN=0 -> read issued, load_data=0x8899AABB.
- TIMEOUT=16, no ack -> mem_rd_req high for 16 cycles, then done with bus_err=1. Ack on the 16th WAIT cycle -> normal completion, bus_err=0.
- start pulses while busy, stray ack in IDLE, and load_type=111 -> no state change and no done; the next valid start completes normally.
- rst_n low during WAIT -> all outputs 0 immediately. After release, a fresh LB request completes correctly.
